// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the MIPS-subset CPU
//
// Purpose: fetch FSM state encoding, PC increment and instruction field
//          positions used by ifetch_unit and next_pc_calc.
// Ports:   none (package).
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } ifetch_state_t;

  localparam logic [31:0] PC_INCR = 32'd4;

  // Instruction field positions
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection for the fetch stage
//
// Purpose: computes pc_plus4 of the held instruction and the next fetch
//          address (jump > taken branch > sequential).
// Ports:
//   ir           in  32  held instruction word
//   ir_pc        in  32  address of ir
//   jump         in  1   retiring instruction is J/JAL
//   branch_taken in  1   retiring branch condition holds
//   pc_plus4     out 32  ir_pc + 4 (wraps mod 2^32)
//   next_pc      out 32  selected next fetch address (raw, unmasked)
//   misaligned   out 1   next_pc[1:0] != 0
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  input  logic [31:0] ir_pc,
  input  logic        jump,
  input  logic        branch_taken,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] jump_target;
  logic [31:0] br_offset;
  logic [31:0] branch_target;
  logic [5:0]  unused_op;

  assign pc_plus4      = ir_pc + PC_INCR;
  // Jump stays within the 256 MB region of the instruction after the jump.
  assign jump_target   = {pc_plus4[31:28], ir[TARGET_MSB:TARGET_LSB], 2'b00};
  assign br_offset     = {{14{ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB], 2'b00};
  assign branch_target = pc_plus4 + br_offset;
  assign unused_op     = ir[OP_MSB:OP_LSB];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, imem handshake, ir register
//
// Purpose: holds the PC, fetches one word per request (one outstanding at a
//          time), presents it as ir and advances the PC when ir retires.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (misaligned next PC -> HALT,
//          sticky fetch_err). Without it the low PC bits are forced to 0.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     out  fetch request (held until ack) and word address
//   imem_ack/rdata    in   accept strobe and instruction word (same cycle)
//   ir, ir_valid      out  held instruction and its valid flag
//   ir_ready          in   downstream retires ir this cycle
//   pc_plus4          out  address of ir + 4
//   jump/branch_taken in   redirect controls, sampled on retire only
//   fetch_err         out  sticky misaligned-target flag
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        branch_taken,
  output logic        fetch_err
);

  ifetch_state_t state, state_d;
  logic [31:0]   pc;
  logic [31:0]   ir_pc;
  logic [31:0]   next_pc;
  logic [31:0]   pc_load_val;
  logic          misaligned;
  logic          load_pc;
  logic          take_ir;

  next_pc_calc u_next_pc (
    .ir           (ir),
    .ir_pc        (ir_pc),
    .jump         (jump),
    .branch_taken (branch_taken),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

`ifdef IFETCH_ALIGN_CHECK_EN
  logic set_err;
  assign pc_load_val = next_pc;
`else
  logic unused_align;
  assign pc_load_val  = {next_pc[31:2], 2'b00};
  assign unused_align = ^{misaligned, next_pc[1:0]};
`endif

  always_comb begin
    state_d = state;
    load_pc = 1'b0;
    take_ir = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    set_err = 1'b0;
`endif
    case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          take_ir = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ir_ready) begin
`ifdef IFETCH_ALIGN_CHECK_EN
          if (misaligned) begin
            set_err = 1'b1;
            state_d = HALT;
          end else begin
            load_pc = 1'b1;
            state_d = FETCH;
          end
`else
          load_pc = 1'b1;
          state_d = FETCH;
`endif
        end
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= 32'd0;
      ir_pc <= RESET_PC;
    end else begin
      state <= state_d;
      if (load_pc) begin
        pc <= pc_load_val;
      end
      if (take_ir) begin
        ir    <= imem_rdata;
        ir_pc <= pc;
      end
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err <= 1'b0;
    end else if (set_err) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

  // Decoded from registered state/pc only: no input-to-output paths.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign ir_valid  = (state == HOLD);

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the MIPS-subset CPU. It holds the program counter, fetches one 32-bit instruction word per request from instruction memory over a req/ack handshake, and presents it as `ir` to the downstream controller/decode stage. It computes the next PC from the retiring instruction: sequential, jump (`Jump` from the controller) or taken branch (from the condition evaluator). There are no delay slots and at most one request is outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000, fetch address after reset; must be word-aligned.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_req`  out  1  fetch request; held until acked.
- `imem_addr`  out  32  word address of the request; stable while `imem_req`=1.
- `imem_ack`  in  1  memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `ir`  out  32  current instruction to the controller.
- `ir_valid`  out  1  `ir` holds a fetched, not-yet-retired instruction.
- `ir_ready`  in  1  downstream retires `ir` this cycle.
- `pc_plus4`  out  32  address of `ir` + 4.
- `jump`  in  1  retiring instruction is J/JAL (controller `Jump`).
- `branch_taken`  in  1  retiring instruction is a branch whose condition holds.
- `fetch_err`  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- States: IDLE, FETCH, HOLD, and HALT (HALT exists only with the macro).
- Reset values: state=IDLE, `pc`=`RESET_PC`, `ir`=0, `ir_pc`=`RESET_PC`, `ir_valid`=0, `imem_req`=0, `fetch_err`=0.
- IDLE: one cycle with no request, then FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. When `imem_ack`=1, register `ir`←`imem_rdata`, `ir_pc`←`pc`, and enter HOLD.
- HOLD: `ir_valid`=1 and `imem_req`=0. When `ir_ready`=1, load `pc` with the next PC and enter FETCH.
- Next PC, in priority order:
  - `jump`: {`pc_plus4`[31:28], `ir`[25:0], 2'b00}.
  - `branch_taken`: `pc_plus4` + {{14{`ir`[15]}}, `ir`[15:0], 2'b00}.
  - Otherwise: `pc_plus4`.
- `pc_plus4` = `ir_pc` + 4, computed mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- `jump` and `branch_taken` are sampled only in a HOLD cycle with `ir_ready`=1; at any other time they are ignored.
- `imem_ack` is ignored outside FETCH.
- Reset asserted mid-FETCH abandons the request. Instruction memory is also reset by `rst_n`, so it never returns a stale ack.
- `ir` and `ir_pc` are unchanged outside the FETCH→HOLD transfer.

## Timing
- Minimum latency: ack in the first FETCH cycle → `ir_valid` the next cycle.
- Best-case throughput: 2 cycles per instruction (FETCH, HOLD). Memory wait cycles extend FETCH.
- A `ir_ready` stall extends HOLD; `ir` stays stable throughout.
- The first request is issued in cycle 2 after `rst_n` rises (IDLE occupies cycle 1).
- Outputs are registered except `imem_req`, `imem_addr` and `ir_valid`, which are decoded from state and `pc` (glitch-free, no input paths).
- There are no combinational paths from inputs to outputs.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - If a next-PC value with bits [1:0]≠0 is selected in HOLD, enter HALT instead of FETCH and set `fetch_err`=1.
  - HALT issues no requests and keeps `ir_valid`=0. Only reset leaves HALT.
- `IFETCH_ALIGN_CHECK_EN` undefined:
  - Bits [1:0] of the next PC are forced to 0.
  - `fetch_err` is tied to 0 and HALT is not built.
  - Note: with the current target formulas the low bits are always 0, so the check guards against future target sources.

## Structure
- Shared package `cpu_pkg`:
  - `ifetch_state_t` enum (IDLE, FETCH, HOLD, HALT).
  - Localparam `PC_INCR`=4.
  - Instruction field positions: target [25:0], imm [15:0], op [31:26].
- One sub-module, `next_pc_calc`: combinational; inputs `ir`, `ir_pc`, `jump`, `branch_taken`; outputs `pc_plus4`, `next_pc`, `misaligned`.
- The FSM, registers and handshake live in `ifetch_unit`.

## Test plan
- Reset with `RESET_PC`=32'h0000_0040, memory acks immediately → `imem_addr`=0x40 in cycle 2, `ir_valid` in cycle 3, `pc_plus4`=0x44.
- Ack delayed 3 cycles, `ir_ready` held low 2 cycles → `imem_addr` stays stable, `ir` stays stable, exactly one request per instruction.
- `ir`=32'h0800_0010 (J) at `ir_pc`=0x1000_0000 with `jump`=1 and `ir_ready`=1 → next `imem_addr`=0x1000_0040.
- `ir`=32'h1000_FFFF (BEQ, imm −1) at `ir_pc`=0x100 with `branch_taken`=1 → next `imem_addr`=0x100. Repeat with `jump`=1 and `branch_taken`=1 → the jump target wins.
- `ir_pc`=0xFFFF_FFFC, sequential → next `imem_addr`=0x0.
- Assert `rst_n` low mid-FETCH → all outputs return to reset values immediately. With `IFETCH_ALIGN_CHECK_EN`, force a misaligned next PC → `fetch_err`=1, `imem_req`=0 until reset.
